// File: rtl/conv_accumulator.sv
// Convolution window accumulator: bias plus KERNEL_SIZE signed products, optional ReLU,
// saturated to the data word and held until downstream accepts it.
module conv_accumulator #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned KERNEL_SIZE = 25,
    parameter int unsigned RELU_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  prod_valid,
    input  logic [DATA_WIDTH-1:0] prod_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int unsigned CNT_W    = $clog2(KERNEL_SIZE + 1);
    localparam int unsigned EXT_W    = ACC_WIDTH - DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_SIZE - 1);

    // Largest / smallest representable output word, in accumulator and word widths
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(EXT_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_WIDTH-1:0] WORD_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] WORD_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ACCUM = 3'b010,
        DONE  = 3'b100
    } state_e;

    state_e                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;

    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  relu_sum;
    logic [DATA_WIDTH-1:0]        sat_word;
    logic                         last_prod;

    assign bias_ext  = {{EXT_W{bias_in[DATA_WIDTH-1]}}, bias_in};
    assign prod_ext  = {{EXT_W{prod_in[DATA_WIDTH-1]}}, prod_in};
    assign sum       = acc_q + prod_ext;
    assign last_prod = prod_valid && (count_q == LAST_CNT);

    // Final-sum post-processing: optional ReLU, then clamp into the output word
    always_comb begin
        relu_sum = sum;
        if ((RELU_EN != 0) && sum[ACC_WIDTH-1]) begin
            relu_sum = '0;
        end
        sat_word = relu_sum[DATA_WIDTH-1:0];
        if (relu_sum > SAT_MAX) begin
            sat_word = WORD_MAX;
        end else if (relu_sum < SAT_MIN) begin
            sat_word = WORD_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (last_prod) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias_ext;
                    count_d = '0;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_d   = sum;
                    count_d = count_q + CNT_W'(1);
                end
                if (last_prod) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sat_word;
                end
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_accumulator.sv
// Randomized self-checking bench for conv_accumulator; ReLU and non-ReLU instances
// share stimulus and are compared against a plain-arithmetic window model.
module tb_conv_accumulator;

    localparam int DW = 16;
    localparam int KS = 25;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] bias_in;
    logic          prod_valid;
    logic [DW-1:0] prod_in;
    logic          out_ready;
    logic          ov_r, ov_n, busy_r, busy_n;
    logic [DW-1:0] od_r, od_n;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] prods[$];

    always #5 clk = ~clk;

    conv_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .KERNEL_SIZE(KS), .RELU_EN(1)) u_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .bias_in(bias_in),
        .prod_valid(prod_valid), .prod_in(prod_in), .out_ready(out_ready),
        .out_valid(ov_r), .out_data(od_r), .busy(busy_r)
    );

    conv_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .KERNEL_SIZE(KS), .RELU_EN(0)) u_lin (
        .clk(clk), .rst_n(rst_n), .start(start), .bias_in(bias_in),
        .prod_valid(prod_valid), .prod_in(prod_in), .out_ready(out_ready),
        .out_valid(ov_n), .out_data(od_n), .busy(busy_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Window result from the arithmetic definition: bias + sum of products, ReLU, clamp
    function automatic logic [DW-1:0] model(input logic [DW-1:0] bias, input bit relu);
        longint s = longint'($signed(bias));
        foreach (prods[i]) s += longint'($signed(prods[i]));
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return DW'(s);
    endfunction

    task automatic fill_const(input logic [DW-1:0] v);
        prods.delete();
        repeat (KS) prods.push_back(v);
    endtask

    task automatic fill_rand();
        logic [DW-1:0] v;
        prods.delete();
        for (int i = 0; i < KS; i++) begin
            v = DW'($urandom);
            if ($urandom_range(0, 1) == 0) v = DW'($signed(v) >>> 5);
            prods.push_back(v);
        end
    endtask

    // Inputs change on falling edges; outputs are sampled there too
    task automatic run_window(input string name, input logic [DW-1:0] bias,
                              input int gap_max, input int hold);
        logic [DW-1:0] exp_r, exp_n;
        exp_r = model(bias, 1'b1);
        exp_n = model(bias, 1'b0);
        // Products offered while idle must be ignored
        prod_valid = 1'b1; prod_in = DW'($urandom);
        @(negedge clk);
        check({name, "_idle_busy"}, 32'(busy_r), 32'd0);
        prod_valid = 1'b0;
        start = 1'b1; bias_in = bias;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_accum"}, 32'(busy_r), 32'd1);
        for (int i = 0; i < KS; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                prod_valid = 1'b0; prod_in = DW'($urandom);
                start = 1'($urandom_range(0, 1)); bias_in = DW'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            if (i == KS - 1) check({name, "_valid_early"}, 32'(ov_r), 32'd0);
            prod_valid = 1'b1; prod_in = prods[i];
            @(negedge clk);
        end
        prod_valid = 1'b0;
        check({name, "_valid"}, 32'({ov_r, ov_n}), 32'b11);
        check({name, "_data_relu"}, 32'(od_r), 32'(exp_r));
        check({name, "_data_lin"}, 32'(od_n), 32'(exp_n));
        for (int c = 0; c < hold; c++) begin
            start = 1'($urandom_range(0, 1)); bias_in = DW'($urandom);
            prod_valid = 1'($urandom_range(0, 1)); prod_in = DW'($urandom);
            @(negedge clk);
            check({name, "_hold"}, {ov_r, busy_r, 14'd0, od_r}, {2'b11, 14'd0, exp_r});
        end
        prod_valid = 1'b0;
        out_ready = 1'b1; start = 1'($urandom_range(0, 1));
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check({name, "_release"}, 32'({ov_r, busy_r, ov_n, busy_n}), 32'd0);
        @(negedge clk);
        check({name, "_no_restart"}, 32'({busy_r, busy_n}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bias_in = '0;
        prod_valid = 1'b0; prod_in = '0; out_ready = 1'b0;
        #23;
        check("reset_outputs", {ov_r, busy_r, 14'd0, od_r}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_const(16'h0100);
        run_window("nominal", 16'h1000, 0, 5);
        check("nominal_value", 32'(model(16'h1000, 1'b1)), 32'h2900);
        run_window("gaps", 16'h1000, 3, 2);

        fill_const(16'hF000);
        run_window("negative", 16'h0000, 1, 1);

        fill_const(16'h7FFF);
        run_window("pos_sat", 16'h7FFF, 0, 0);

        for (int w = 0; w < 8; w++) begin
            fill_rand();
            run_window("random", DW'($urandom), 3, $urandom_range(0, 5));
        end

        // Asynchronous reset after 10 products of a window
        fill_const(16'h0100);
        start = 1'b1; bias_in = 16'h1000;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            prod_valid = 1'b1; prod_in = prods[i];
            @(negedge clk);
        end
        prod_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {ov_r, busy_r, ov_n, busy_n, 12'd0, od_r}, 32'd0);
        check("async_reset_lin", 32'(od_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(busy_r), 32'd0);
        run_window("after_reset", 16'h1000, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
